// File: rtl/uart_rx_param_if.sv
// Port bundle of the parametrised UART receiver: serial line in, valid/ready word out.
// The receiver is the master of the word stream; the consumer side uses the slave modport.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_i;
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 frame_err_o;
    logic                 parity_err_o;
    logic                 overrun_o;
    logic                 busy_o;

    modport master (
        input  rx_i, ready_i,
        output data_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o
    );

    modport slave (
        output rx_i, ready_i,
        input  data_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample mid-bit majority vote, optional parity, 1/2 stop bits,
// and a valid/ready holding register with overrun detection.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clock,
    input  logic            reset,
    uart_rx_param_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(HALF + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nx;
    logic                 rx_m, rx_s, rx_d;
    logic [1:0]           fill;
    logic                 armed;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 stop_idx;
    logic                 smp_a, smp_b;
    logic [DATA_BITS-1:0] shift;
    logic                 par_acc, ferr_pend, perr_pend;
    logic                 boundary, decide, vote, fall, stop_last, commit;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, ferr_q, perr_q, ovr_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Synchroniser plus edge register; fill marks when rx_s reflects the real line,
    // so a line that is already low when reset drops never looks like a start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            rx_m <= bus.rx_i;
            rx_s <= rx_m;
            rx_d <= rx_s;
            fill <= {fill[0], 1'b1};
            if (fill[1] && rx_s) armed <= 1'b1;
        end
    end

    assign fall      = armed & rx_d & ~rx_s;
    assign boundary  = (cnt == CNT_LAST);
    assign decide    = (cnt == SMP_C);
    assign vote      = maj3(smp_a, smp_b, rx_s);
    assign stop_last = (STOP_BITS == 1) || stop_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        unique case (state)
            IDLE:   if (fall) state_nx = START;
            START: begin
                if (decide && vote) state_nx = IDLE;
                else if (boundary)  state_nx = DATA;
            end
            DATA:   if (boundary && idx == IDX_LAST) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (boundary) state_nx = STOP;
            STOP: begin
                // Commit at the decision point so the next start edge is not missed.
                if (decide && stop_last) begin
                    commit   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= '0;
            stop_idx  <= 1'b0;
            smp_a     <= 1'b1;
            smp_b     <= 1'b1;
            shift     <= '0;
            par_acc   <= 1'b0;
            ferr_pend <= 1'b0;
            perr_pend <= 1'b0;
        end else begin
            if (state == IDLE || state_nx == IDLE || boundary) cnt <= '0;
            else                                               cnt <= cnt + 1'b1;
            if (cnt == SMP_A) smp_a <= rx_s;
            if (cnt == SMP_B) smp_b <= rx_s;
            unique case (state)
                START: begin
                    idx       <= '0;
                    stop_idx  <= 1'b0;
                    par_acc   <= 1'b0;
                    ferr_pend <= 1'b0;
                    perr_pend <= 1'b0;
                end
                DATA: begin
                    // LSB arrives first, so shifting in from the top leaves bit 0 at shift[0].
                    if (decide) begin
                        shift   <= {vote, shift[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ vote;
                    end
                    if (boundary) idx <= idx + 1'b1;
                end
                PARITY: if (decide && (vote != (par_acc ^ ODD))) perr_pend <= 1'b1;
                STOP: begin
                    if (decide && !vote) ferr_pend <= 1'b1;
                    if (boundary)        stop_idx  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Holding register: a read in the commit cycle frees the slot for the new word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (commit) begin
                if (!valid_q || bus.ready_i) begin
                    data_q  <= shift;
                    ferr_q  <= ferr_pend | ~vote;
                    perr_q  <= perr_pend;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data_o       = data_q;
    assign bus.valid_o      = valid_q;
    assign bus.frame_err_o  = ferr_q;
    assign bus.parity_err_o = perr_q;
    assign bus.overrun_o    = ovr_q;
    assign bus.busy_o       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three builds (8N1, 8E1, 7N2) driven with directed and random frames
// and scored against a frame-level reference model.
module tb_uart_rx_param;
    localparam int CPB = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_param_if #(.DATA_BITS(8)) bus_p ();
    uart_rx_param_if #(.DATA_BITS(7)) bus_b ();

    logic rx_line [3];
    logic rdy     [3];

    assign bus_a.rx_i    = rx_line[0];
    assign bus_p.rx_i    = rx_line[1];
    assign bus_b.rx_i    = rx_line[2];
    assign bus_a.ready_i = rdy[0];
    assign bus_p.ready_i = rdy[1];
    assign bus_b.ready_i = rdy[2];

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut_p (.clock(clock), .reset(reset), .bus(bus_p));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    logic [8:0] dout [3];
    logic       vld [3], fe [3], pe [3], ov [3], bsy [3];

    assign dout[0] = {1'b0, bus_a.data_o};
    assign dout[1] = {1'b0, bus_p.data_o};
    assign dout[2] = {2'b00, bus_b.data_o};
    assign vld[0] = bus_a.valid_o;      assign vld[1] = bus_p.valid_o;      assign vld[2] = bus_b.valid_o;
    assign fe[0]  = bus_a.frame_err_o;  assign fe[1]  = bus_p.frame_err_o;  assign fe[2]  = bus_b.frame_err_o;
    assign pe[0]  = bus_a.parity_err_o; assign pe[1]  = bus_p.parity_err_o; assign pe[2]  = bus_b.parity_err_o;
    assign ov[0]  = bus_a.overrun_o;    assign ov[1]  = bus_p.overrun_o;    assign ov[2]  = bus_b.overrun_o;
    assign bsy[0] = bus_a.busy_o;       assign bsy[1] = bus_p.busy_o;       assign bsy[2] = bus_b.busy_o;

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t qa[$], qp[$], qb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ov_cnt [3] = '{0, 0, 0};
    bit   popped [3] = '{0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int dbits_of(input int k);
        return (k == 2) ? 7 : 8;
    endfunction

    function automatic int nstop_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    // Frame-level expectation: data bits as sent, any 0 stop bit is a framing error,
    // and a parity bit that does not make the count of ones even (or odd) is a parity error.
    function automatic exp_t model(input logic [8:0] data, input int dbits, input int par_mode,
                                   input int odd, input logic [1:0] stops, input int nstop);
        exp_t e;
        int   ones = 0;
        e.data = '0;
        for (int i = 0; i < dbits; i++) begin
            e.data[i] = data[i];
            ones += int'(data[i]);
        end
        e.pe = (par_mode >= 0) && (par_mode != ((ones + odd) % 2));
        e.fe = 1'b0;
        for (int s = 0; s < nstop; s++) if (stops[s] == 1'b0) e.fe = 1'b1;
        return e;
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return qa.size();
            1:       return qp.size();
            default: return qb.size();
        endcase
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0:       qa.push_back(e);
            1:       qp.push_back(e);
            default: qb.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int k, output exp_t e, output bit ok);
        ok = (qsize(k) != 0);
        e  = '0;
        if (ok) begin
            case (k)
                0:       e = qa.pop_front();
                1:       e = qp.pop_front();
                default: e = qb.pop_front();
            endcase
        end
    endtask

    exp_t mon_e;
    bit   mon_ok;

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                popped[k] = 1'b0;
            end else begin
                if (ov[k]) ov_cnt[k]++;
                if (popped[k]) check($sformatf("valid_one_cycle%0d", k), vld[k], 0);
                popped[k] = 1'b0;
                if (vld[k] && rdy[k]) begin
                    pop_exp(k, mon_e, mon_ok);
                    if (!mon_ok) begin
                        check($sformatf("unexpected_valid%0d", k), 1, 0);
                    end else begin
                        check($sformatf("data%0d", k), dout[k], mon_e.data);
                        check($sformatf("frame_err%0d", k), fe[k], mon_e.fe);
                        check($sformatf("parity_err%0d", k), pe[k], mon_e.pe);
                    end
                    popped[k] = 1'b1;
                end
            end
        end
    end

    task automatic idle(input int k, input int nbits);
        @(negedge clock);
        rx_line[k] = 1'b1;
        repeat (nbits * CPB - 1) @(negedge clock);
    endtask

    // Drives one frame; a single-clock inverted glitch lands at clock goff of bit gbit (gbit<0: none).
    task automatic tx(input int k, input logic [8:0] data, input int par_mode, input logic [1:0] stops,
                      input int gbit, input int goff, input bit expect_it);
        logic b [16];
        int   n = 0;
        if (expect_it)
            push_exp(k, model(data, dbits_of(k), par_mode, 0, stops, nstop_of(k)));
        b[n] = 1'b0; n++;
        for (int i = 0; i < dbits_of(k); i++) begin b[n] = data[i]; n++; end
        if (par_mode >= 0) begin b[n] = par_mode[0]; n++; end
        for (int s = 0; s < nstop_of(k); s++) begin b[n] = stops[s]; n++; end
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clock);
                rx_line[k] = b[i] ^ ((i == gbit) && (c == goff));
            end
        end
    endtask

    task automatic wait_drain(input int k);
        int guard = 0;
        while (qsize(k) != 0 && guard < 4000) begin
            @(negedge clock);
            guard++;
        end
        check($sformatf("drain%0d", k), qsize(k), 0);
    endtask

    initial begin
        int         k, pm, gb, ov0;
        logic [8:0] d;
        logic [1:0] st;
        logic [7:0] v5a;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin rx_line[i] = 1'b1; rdy[i] = 1'b1; end
        repeat (3) @(negedge clock);
        check("rst_valid", bus_a.valid_o, 0);
        check("rst_data", bus_a.data_o, 0);
        check("rst_frame_err", bus_a.frame_err_o, 0);
        check("rst_parity_err", bus_a.parity_err_o, 0);
        check("rst_overrun", bus_a.overrun_o, 0);
        check("rst_busy", bus_a.busy_o, 0);
        reset = 1'b0;
        idle(0, 2);

        // Plain 8N1 frame
        tx(0, 9'h0A5, -1, 2'b11, -1, 0, 1'b1);
        idle(0, 2);
        wait_drain(0);
        check("no_overrun_8n1", ov_cnt[0], 0);

        // Even parity: correct, then wrong parity bit
        tx(1, 9'h003, 0, 2'b11, -1, 0, 1'b1);
        idle(1, 1);
        tx(1, 9'h003, 1, 2'b11, -1, 0, 1'b1);
        idle(1, 2);
        wait_drain(1);

        // Framing error, line break, recovery
        tx(0, 9'h03C, -1, 2'b00, -1, 0, 1'b1);
        idle(0, 2);
        push_exp(0, model(9'h000, 8, -1, 0, 2'b00, 1));
        @(negedge clock);
        rx_line[0] = 1'b0;
        repeat (20 * CPB) @(negedge clock);
        idle(0, 2);
        wait_drain(0);
        tx(0, 9'h011, -1, 2'b11, -1, 0, 1'b1);
        idle(0, 2);
        wait_drain(0);

        // False start and mid-bit glitch
        @(negedge clock);
        rx_line[0] = 1'b0;
        repeat (4) @(negedge clock);
        rx_line[0] = 1'b1;
        check("glitch_busy_high", bus_a.busy_o, 1);
        repeat (2 * CPB) @(negedge clock);
        check("glitch_busy_low", bus_a.busy_o, 0);
        check("glitch_no_valid", bus_a.valid_o, 0);
        tx(0, 9'h0FF, -1, 2'b11, 4, 9, 1'b1);
        idle(0, 2);
        wait_drain(0);

        // Overrun with ready held low
        rdy[0] = 1'b0;
        ov0 = ov_cnt[0];
        tx(0, 9'h011, -1, 2'b11, -1, 0, 1'b1);
        tx(0, 9'h022, -1, 2'b11, -1, 0, 1'b0);
        idle(0, 2);
        check("ovr_valid_held", bus_a.valid_o, 1);
        check("ovr_data_kept", bus_a.data_o, 8'h11);
        check("ovr_pulses", ov_cnt[0] - ov0, 1);
        rdy[0] = 1'b1;
        repeat (3) @(negedge clock);
        check("ovr_valid_cleared", bus_a.valid_o, 0);
        check("ovr_data_after_read", bus_a.data_o, 8'h11);
        wait_drain(0);

        // Reset during data bit 4 of 0x5A; dut_b sees a low line out of reset
        v5a = 8'h5A;
        @(negedge clock);
        rx_line[0] = 1'b0;
        repeat (CPB - 1) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx_line[0] = v5a[i];
            repeat (CPB) @(negedge clock);
        end
        rx_line[0] = v5a[4];
        repeat (CPB / 2) @(negedge clock);
        check("pre_reset_busy", bus_a.busy_o, 1);
        reset = 1'b1;
        rx_line[2] = 1'b0;
        #1;
        check("mid_rst_busy", bus_a.busy_o, 0);
        check("mid_rst_valid", bus_a.valid_o, 0);
        check("mid_rst_data", bus_a.data_o, 0);
        check("mid_rst_frame_err", bus_a.frame_err_o, 0);
        check("mid_rst_parity_err", bus_a.parity_err_o, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rx_line[0] = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        check("low_line_no_start", bus_b.busy_o, 0);
        check("post_rst_no_valid", bus_a.valid_o, 0);
        idle(2, 2);
        tx(0, 9'h077, -1, 2'b11, -1, 0, 1'b1);
        idle(0, 2);
        wait_drain(0);
        tx(2, 9'h055, -1, 2'b11, -1, 0, 1'b1);
        idle(2, 2);
        wait_drain(2);

        // Random frames on all three builds
        for (int it = 0; it < 30; it++) begin
            k  = $urandom_range(0, 2);
            d  = 9'($urandom);
            st = 2'b11;
            if ($urandom_range(0, 3) == 0) st[0] = 1'b0;
            if ($urandom_range(0, 3) == 0) st[1] = 1'b0;
            pm = (k == 1) ? int'($urandom_range(0, 1)) : -1;
            gb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, dbits_of(k))) : -1;
            tx(k, d, pm, st, gb, int'($urandom_range(8, 10)), 1'b1);
            idle(k, 1);
            repeat ($urandom_range(0, 7)) @(negedge clock);
            wait_drain(k);
        end

        check("overrun_total_a", ov_cnt[0], 1);
        check("overrun_total_p", ov_cnt[1], 0);
        check("overrun_total_b", ov_cnt[2], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
